// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings, instruction field positions
// and the fetch sequencer state encoding.
package cpu_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'd0;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_ADDI   = 6'd8;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    localparam logic [5:0] FN_ADD    = 6'd32;
    localparam logic [5:0] FN_SUB    = 6'd34;
    localparam logic [5:0] FN_JR     = 6'd8;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int IMM_MSB    = 15;
    localparam int TARGET_MSB = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        RESOLVE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for a resolved instruction: jump_reg > jump > taken branch > pc+1.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  rs_val,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic               branch_eq,
    input  logic               branch_ne,
    input  logic               alu_zero,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W-1:0] pc_inc;
    logic [31:0]       imm_ext;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              unused_instr;

    assign unused_instr = ^instr;
    assign pc_inc  = pc + ADDR_W'(1);
    // Sign-extend to 32 bits first, then truncate: arithmetic stays mod 2^ADDR_W.
    assign imm_ext = 32'(signed'(instr[IMM_MSB:0]));
    assign target  = ADDR_W'(instr[TARGET_MSB:0]);
    assign taken   = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);

    always_comb begin
        next_pc = pc_inc;
        if (jump_reg)
            next_pc = rs_val;
        else if (jump)
            next_pc = target;
        else if (taken)
            next_pc = pc_inc + imm_ext[ADDR_W-1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch / PC sequencer: fetch, hand to decode, wait for
// the control outcome, then compute the next PC.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [ADDR_W-1:0]  link_pc,
    input  logic               resolve_valid,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic               branch_eq,
    input  logic               branch_ne,
    input  logic               alu_zero,
    input  logic [ADDR_W-1:0]  rs_val,
    output logic [31:0]        retired_cnt,
    output logic               proto_err
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  link_pc_q, link_pc_d;
    logic [31:0]        retired_q, retired_d;
    logic               proto_err_q, proto_err_d;
    logic [ADDR_W-1:0]  next_pc;

    next_pc_calc #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_next_pc (
        .pc        (pc_q),
        .instr     (instr_q),
        .rs_val    (rs_val),
        .jump      (jump),
        .jump_reg  (jump_reg),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .alu_zero  (alu_zero),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        link_pc_d   = link_pc_q;
        retired_d   = retired_q;
        proto_err_d = proto_err_q;

        // Handshakes arriving in the wrong state are flagged and otherwise dropped.
        if ((imem_ack && state_q != FETCH) ||
            (resolve_valid && state_q != RESOLVE) ||
            (instr_ready && state_q != ISSUE))
            proto_err_d = 1'b1;

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ack) begin
                         instr_d   = imem_rdata;
                         link_pc_d = pc_q + ADDR_W'(1);
                         state_d   = ISSUE;
                     end
            ISSUE:   if (instr_ready) state_d = RESOLVE;
            RESOLVE: if (resolve_valid) begin
                         pc_d      = next_pc;
                         retired_d = retired_q + 32'd1;
                         state_d   = FETCH;
                     end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            link_pc_q   <= '0;
            retired_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            link_pc_q   <= link_pc_d;
            retired_q   <= retired_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign funct       = instr_q[FUNCT_MSB:0];
    assign link_pc     = link_pc_q;
    assign retired_cnt = retired_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequencing, next-PC priority,
// wrap-around and protocol-error handling with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [15:0] link_pc;
    logic        resolve_valid = 1'b0;
    logic        jump = 1'b0, jump_reg = 1'b0, branch_eq = 1'b0, branch_ne = 1'b0;
    logic        alu_zero = 1'b0;
    logic [15:0] rs_val = '0;
    logic [31:0] retired_cnt;
    logic        proto_err;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_ret = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .funct(funct), .link_pc(link_pc),
        .resolve_valid(resolve_valid), .jump(jump), .jump_reg(jump_reg),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .alu_zero(alu_zero),
        .rs_val(rs_val), .retired_cnt(retired_cnt), .proto_err(proto_err)
    );

    // Stimulus drivers: each is entered at a negedge and returns at a negedge.
    task automatic ack_word(input logic [31:0] w);
        imem_rdata = w; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic resolve(input logic jr, input logic j, input logic beq,
                           input logic bne, input logic z, input logic [15:0] rs);
        jump_reg = jr; jump = j; branch_eq = beq; branch_ne = bne;
        alu_zero = z; rs_val = rs; resolve_valid = 1'b1;
        @(negedge clk);
        resolve_valid = 1'b0; jump_reg = 1'b0; jump = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0; rs_val = '0;
        exp_ret = exp_ret + 1;
    endtask

    task automatic jr_to(input logic [15:0] a);
        ack_word(32'h0000_0000);
        accept();
        resolve(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vecs++;
        if ({imem_req, imem_addr, instr_valid, instr, opcode, funct, link_pc, retired_cnt, proto_err}
            !== '0) begin
            errs++;
            $display("FAIL reset_vals got req=%b addr=%h v=%b instr=%h link=%h ret=%0d err=%b exp all zero",
                     imem_req, imem_addr, instr_valid, instr, link_pc, retired_cnt, proto_err);
        end
        rst_n = 1'b1;
        #1;
        vecs++;
        if (imem_req !== 1'b0) begin errs++; $display("FAIL idle_no_req got %b exp 0", imem_req); end
        @(negedge clk);
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errs++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        ack_word(32'h2001_0005);
        vecs++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h2001_0005 ||
            opcode !== 6'd8 || funct !== 6'd5 || link_pc !== 16'h0001) begin
            errs++;
            $display("FAIL basic_issue got v=%b req=%b instr=%h op=%0d fn=%0d link=%h exp 1 0 20010005 8 5 0001",
                     instr_valid, imem_req, instr, opcode, funct, link_pc);
        end
        accept();
        vecs++;
        if (instr_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_drop got %b exp 0", instr_valid); end
        resolve(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || retired_cnt !== 32'd1) begin
            errs++;
            $display("FAIL basic_next got req=%b addr=%h ret=%0d exp 1 0001 1", imem_req, imem_addr, retired_cnt);
        end
    endtask

    task automatic test_branch();
        jr_to(16'h0010);
        ack_word(32'h1000_FFFE);
        accept();
        resolve(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        vecs++;
        if (imem_addr !== 16'h000F || retired_cnt !== exp_ret) begin
            errs++; $display("FAIL beq_taken got addr=%h ret=%0d exp 000f %0d", imem_addr, retired_cnt, exp_ret);
        end
        jr_to(16'h0010);
        ack_word(32'h1000_FFFE);
        accept();
        resolve(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        vecs++;
        if (imem_addr !== 16'h0011) begin errs++; $display("FAIL beq_not_taken got %h exp 0011", imem_addr); end
        // BNE taken when alu_zero=0: 0x11+1+3 = 0x15
        ack_word(32'h1400_0003);
        accept();
        resolve(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        vecs++;
        if (imem_addr !== 16'h0015) begin errs++; $display("FAIL bne_taken got %h exp 0015", imem_addr); end
    endtask

    task automatic test_priority();
        jr_to(16'h0020);
        ack_word(32'h0800_5555);
        accept();
        resolve(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
        vecs++;
        if (imem_addr !== 16'h1234) begin errs++; $display("FAIL jr_over_j got %h exp 1234", imem_addr); end
        ack_word(32'h0800_0040);
        accept();
        resolve(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        vecs++;
        if (imem_addr !== 16'h0040) begin errs++; $display("FAIL j_over_branch got %h exp 0040", imem_addr); end
    endtask

    task automatic test_jal();
        jr_to(16'h0005);
        ack_word(32'h0C00_ABCD);
        vecs++;
        if (link_pc !== 16'h0006 || opcode !== 6'd3) begin
            errs++; $display("FAIL jal_link got link=%h op=%0d exp 0006 3", link_pc, opcode);
        end
        accept();
        resolve(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        vecs++;
        if (imem_addr !== 16'hABCD || link_pc !== 16'h0006) begin
            errs++; $display("FAIL jal_target got addr=%h link=%h exp abcd 0006", imem_addr, link_pc);
        end
    endtask

    task automatic test_wrap();
        jr_to(16'hFFFF);
        ack_word(32'h0022_1820);
        vecs++;
        if (funct !== 6'd32 || link_pc !== 16'h0000) begin
            errs++; $display("FAIL wrap_link got fn=%0d link=%h exp 32 0000", funct, link_pc);
        end
        accept();
        resolve(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        vecs++;
        if (imem_addr !== 16'h0000 || retired_cnt !== exp_ret) begin
            errs++; $display("FAIL wrap_pc got addr=%h ret=%0d exp 0000 %0d", imem_addr, retired_cnt, exp_ret);
        end
    endtask

    task automatic test_proto();
        // instr_ready during FETCH: flagged, no state change
        accept();
        vecs++;
        if (proto_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errs++; $display("FAIL ready_in_fetch got err=%b req=%b addr=%h exp 1 1 0000", proto_err, imem_req, imem_addr);
        end
        ack_word(32'h2001_0007);
        // resolve_valid during ISSUE: ignored, instruction stays presented
        resolve_valid = 1'b1; jump_reg = 1'b1; rs_val = 16'h0777;
        @(negedge clk);
        resolve_valid = 1'b0; jump_reg = 1'b0; rs_val = '0;
        vecs++;
        if (instr_valid !== 1'b1 || retired_cnt !== exp_ret || proto_err !== 1'b1) begin
            errs++; $display("FAIL resolve_in_issue got v=%b ret=%0d err=%b exp 1 %0d 1", instr_valid, retired_cnt, proto_err, exp_ret);
        end
        accept();
        resolve(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        vecs++;
        if (imem_addr !== 16'h0001 || proto_err !== 1'b1) begin
            errs++; $display("FAIL proto_sticky got addr=%h err=%b exp 0001 1", imem_addr, proto_err);
        end
    endtask

    task automatic test_reset_mid_fetch();
        // In FETCH at addr 1; ack would arrive 3 cycles after the request.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({imem_req, imem_addr, instr_valid, instr, link_pc, retired_cnt, proto_err} !== '0) begin
            errs++;
            $display("FAIL async_reset got req=%b addr=%h v=%b instr=%h link=%h ret=%0d err=%b exp all zero",
                     imem_req, imem_addr, instr_valid, instr, link_pc, retired_cnt, proto_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ack_word(32'h2001_0009);
        vecs++;
        if (proto_err !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errs++;
            $display("FAIL stale_ack got err=%b v=%b instr=%h req=%b addr=%h exp 1 0 00000000 1 0000",
                     proto_err, instr_valid, instr, imem_req, imem_addr);
        end
        @(negedge clk);
        vecs++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errs++; $display("FAIL no_issue_after_stale got v=%b req=%b exp 0 1", instr_valid, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_priority();
        test_jal();
        test_wrap();
        test_proto();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and PC sequencing block for the multi-cycle 16-bit CPU. It fetches one instruction word from instruction memory and presents it to decode. It then waits for the resolved control outcome of that instruction (jump, jump_reg, branch_eq/branch_ne plus the ALU zero flag) and computes the next PC. It is the producer of the opcode/funct stream that the control unit consumes, and the consumer of that unit's flow-control outputs.

## Interface
- ADDR_W, 16: PC / instruction-memory word-address width.
- INSTR_W, 32: instruction word width; fields fixed: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm16[15:0], target[25:0].
- RESET_PC, 0: PC loaded at reset.
- Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- imem_req, out, 1: fetch request, held until ack.
- imem_addr, out, ADDR_W: word address, stable while imem_req.
- imem_ack, in, 1: one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata, in, INSTR_W: fetched instruction.
- instr_valid, out, 1: instruction presented to decode.
- instr_ready, in, 1: decode accepts.
- instr, out, INSTR_W: registered instruction word.
- opcode, out, 6: instr[31:26].
- funct, out, 6: instr[5:0].
- link_pc, out, ADDR_W: PC+1 of the presented instruction (JAL link value).
- resolve_valid, in, 1: one-cycle pulse; flow-control outcome below is valid.
- jump, jump_reg, branch_eq, branch_ne, in, 1 each: control-unit outputs for the current instruction.
- alu_zero, in, 1: ALU zero flag for branch compare.
- rs_val, in, ADDR_W: register rs value, used as the jump_reg target.
- retired_cnt, out, 32: instructions resolved since reset.
- proto_err, out, 1: sticky flag set on handshake violation.

## Operation
- States: IDLE, FETCH, ISSUE, RESOLVE.
- IDLE: entered only from reset; unconditionally goes to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata into instr, set link_pc=pc+1, and go to ISSUE.
- ISSUE: instr_valid=1. On instr_ready, go to RESOLVE.
- RESOLVE: on resolve_valid, load pc with the next-PC value, increment retired_cnt, and go to FETCH.
- Next-PC priority, highest first:
  - jump_reg: rs_val.
  - jump: target[ADDR_W-1:0].
  - branch taken: pc+1+sext(imm16). Taken means (branch_eq & alu_zero) | (branch_ne & ~alu_zero).
  - otherwise: pc+1.
- All PC arithmetic is modulo 2^ADDR_W, so wrap from 0xFFFF to 0x0000 is legal.
- retired_cnt wraps silently at 2^32.
- proto_err is set, and stays set until reset, on any of:
  - imem_ack outside FETCH;
  - resolve_valid outside RESOLVE;
  - instr_ready outside ISSUE.
- An event that sets proto_err is otherwise ignored and does not change state.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC;
  - imem_req=0, imem_addr=RESET_PC;
  - instr_valid=0, instr=0, opcode=0, funct=0, link_pc=0;
  - retired_cnt=0, proto_err=0.
- imem_req rises on the first edge after rst_n deasserts (through IDLE).
- imem_ack may come the same cycle imem_req is high, at the earliest.
- instr_valid rises on the edge after the ack cycle. imem_req falls on that same edge.
- instr_ready seen in cycle N: instr_valid falls at edge N+1.
- resolve_valid seen in cycle M: the new imem_addr with imem_req=1 appears at edge M+1.
- Minimum instruction period with zero-wait memory and same-cycle ready/resolve: 3 cycles.
- instr, opcode, funct and link_pc hold until the next imem_ack.
- rst_n asserted in any state, including mid-FETCH with an outstanding request: immediate return to reset values. A late imem_ack after reset flags proto_err.

## Structure
- Shared package cpu_pkg holds:
  - opcode and funct constants (R_TYPE=0, J=2, JAL=3, BEQ=4, BNE=5, ADDI=8, LW=35, SW=43, ADD=32, SUB=34, JR=8);
  - instruction field bit positions;
  - the state enum.
- One combinational sub-module, next_pc_calc, takes pc, instr, rs_val, the flow-control bits and alu_zero, and returns next_pc.

## Test plan
- Reset release, RESET_PC=0, zero-wait ack with 0x20010005 -> imem_addr=0, opcode=8, link_pc=1; after resolve with no control bits, next fetch at 1; retired_cnt=1.
- BEQ at pc=0x0010 with imm16=0xFFFE, branch_eq=1, alu_zero=1 -> next imem_addr=0x000F. Same with alu_zero=0 -> 0x0011.
- pc=0x0020, jump_reg=1, jump=1, rs_val=0x1234 -> next fetch at 0x1234 (jump_reg priority).
- JAL with target=0x0000ABCD at pc=0x0005 -> link_pc=0x0006; next fetch at 0xABCD.
- pc=0xFFFF with no flow control -> next fetch at 0x0000.
- rst_n pulsed low while in FETCH awaiting a 3-cycle-latency ack -> all outputs return to reset values; the stale ack arrives in IDLE -> proto_err=1, no instruction issued; the next fetch is at RESET_PC.
